// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl
// Multi-cycle control core for a Hack CPU. It fetches 16-bit instructions,
// decodes them, drives the control and operand inputs of an external Hack
// ALU, and owns the A, D, PC and instruction registers. Instruction and data
// memory use a req/ack handshake, so wait-stated memories are supported.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr = PC)
//   dmem_re/we/addr/wdata    data read/write requests (addr = A[14:0])
//   dmem_ack/rdata           data handshake completion and read word
//   alu_x, alu_y             ALU operands (D, and M or A selected by IR[12])
//   alu_zx..alu_no           ALU control bits taken from IR[11:6]
//   alu_out, alu_zr, alu_ng  ALU result and flags, sampled in EXEC only
//   pc                       current program counter
//   instr_done               one-cycle pulse when an instruction retires
module hack_cpu_ctrl (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [14:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic        dmem_re,
   output logic        dmem_we,
   output logic [14:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic        alu_zx,
   output logic        alu_nx,
   output logic        alu_zy,
   output logic        alu_ny,
   output logic        alu_f,
   output logic        alu_no,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   output logic [14:0] pc,
   output logic        instr_done
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_MREAD,
      S_EXEC,
      S_MWRITE,
      S_COMMIT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] a_q, a_d;
   logic [15:0] d_q, d_d;
   logic [15:0] m_q, m_d;
   logic [15:0] r_q, r_d;
   logic        j_q, j_d;
   logic [14:0] pc_q, pc_d;

   // State and datapath registers; reset aborts any transaction in flight
   // without committing partial results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         a_q     <= '0;
         d_q     <= '0;
         m_q     <= '0;
         r_q     <= '0;
         j_q     <= 1'b0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         d_q     <= d_d;
         m_q     <= m_d;
         r_q     <= r_d;
         j_q     <= j_d;
         pc_q    <= pc_d;
      end
   end

   // Next-state and register-update logic. The jump target and the data
   // address both come from the pre-commit A, so a destination of A only
   // takes effect in COMMIT, after any memory write has finished.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      a_d     = a_q;
      d_d     = d_q;
      m_d     = m_q;
      r_d     = r_q;
      j_d     = j_q;
      pc_d    = pc_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!ir_q[15]) begin
               a_d     = {1'b0, ir_q[14:0]};
               pc_d    = pc_q + 15'd1;
               state_d = S_FETCH;
            end else begin
               state_d = ir_q[12] ? S_MREAD : S_EXEC;
            end
         end
         S_MREAD: begin
            if (dmem_ack) begin
               m_d     = dmem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            r_d     = alu_out;
            j_d     = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) |
                      (ir_q[0] & ~alu_ng & ~alu_zr);
            state_d = ir_q[3] ? S_MWRITE : S_COMMIT;
         end
         S_MWRITE: begin
            if (dmem_ack) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (ir_q[5]) begin
               a_d = r_q;
            end
            if (ir_q[4]) begin
               d_d = r_q;
            end
            pc_d    = j_q ? a_q[14:0] : (pc_q + 15'd1);
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Requests are gated by rst so that they drop the moment reset asserts,
   // independent of the clock.
   assign imem_req   = ~rst & (state_q == S_FETCH);
   assign dmem_re    = ~rst & (state_q == S_MREAD);
   assign dmem_we    = ~rst & (state_q == S_MWRITE);
   assign instr_done = ~rst & (((state_q == S_DECODE) & ~ir_q[15]) |
                               (state_q == S_COMMIT));

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign dmem_addr  = a_q[14:0];
   assign dmem_wdata = r_q;

   assign alu_x  = d_q;
   assign alu_y  = ir_q[12] ? m_q : a_q;
   assign alu_zx = ir_q[11];
   assign alu_nx = ir_q[10];
   assign alu_zy = ir_q[9];
   assign alu_ny = ir_q[8];
   assign alu_f  = ir_q[7];
   assign alu_no = ir_q[6];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl
// Drives hack_cpu_ctrl with a Hack ALU model, randomly wait-stated
// instruction and data memories, a directed program prefix followed by
// random instructions, and a mid-write reset. An instruction-level Hack
// interpreter predicts PC, A, D, memory writes and instruction latency.
module tb_hack_cpu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [14:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_re;
   logic        dmem_we;
   logic [14:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
   logic [15:0] alu_out;
   logic        alu_zr, alu_ng;
   logic [14:0] pc;
   logic        instr_done;

   int errors = 0;
   int checks = 0;

   // Memories: ram is what the DUT sees, refMem is the interpreter's view.
   logic [15:0] ram    [32768];
   logic [15:0] refMem [32768];
   logic [15:0] dirQ   [$];

   bit          iActive, dActive, holdDAck, postPending;
   int          iWait, dWait, forceDWait;
   logic [15:0] curFetch;
   logic [14:0] mPC;
   logic [15:0] mA, mD;
   int          cyc, waits, reads, writes, retired;
   logic [14:0] wAddr;
   logic [15:0] wData;

   hack_cpu_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_x(alu_x), .alu_y(alu_y),
      .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
      .alu_f(alu_f), .alu_no(alu_no),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .pc(pc), .instr_done(instr_done)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // The Hack ALU as defined by the ISA.
   function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      logic [15:0] xv, yv, o;
      xv = c[5] ? 16'h0000 : x;
      xv = c[4] ? ~xv : xv;
      yv = c[3] ? 16'h0000 : y;
      yv = c[2] ? ~yv : yv;
      o  = c[1] ? (xv + yv) : (xv & yv);
      o  = c[0] ? ~o : o;
      return o;
   endfunction

   // External ALU wired combinationally to the core's operand and control outputs.
   assign alu_out = hackAlu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
   assign alu_zr  = (alu_out == 16'h0000);
   assign alu_ng  = alu_out[15];

   function automatic logic [15:0] randInstr();
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 2) == 0) return {1'b0, r[14:0]};
      return {3'b111, r[12:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] instr);
      dirQ.push_back(instr);
   endtask

   // Instruction-level interpreter: executes one retired instruction and
   // compares the observed memory traffic and latency with its prediction.
   task automatic runModel(input logic [15:0] ins);
      logic [15:0] y, o, newA;
      logic        jmp;
      int          expLat;
      expLat = (ins[15] ? 4 + int'(ins[12]) + int'(ins[3]) : 2) + waits;
      checkOutput("latency", cyc, expLat);
      checkOutput("readCount", reads, (ins[15] && ins[12]) ? 1 : 0);
      checkOutput("writeCount", writes, (ins[15] && ins[3]) ? 1 : 0);
      if (!ins[15]) begin
         mA  = {1'b0, ins[14:0]};
         mPC = mPC + 15'd1;
      end else begin
         y   = ins[12] ? refMem[mA[14:0]] : mA;
         o   = hackAlu(mD, y, ins[11:6]);
         jmp = (ins[2] && o[15]) || (ins[1] && o == 16'h0000) ||
               (ins[0] && !o[15] && o != 16'h0000);
         if (ins[3]) begin
            checkOutput("writeAddr", wAddr, mA[14:0]);
            checkOutput("writeData", wData, o);
            refMem[mA[14:0]] = o;
         end
         newA = ins[5] ? o : mA;
         if (ins[4]) mD = o;
         mPC = jmp ? mA[14:0] : mPC + 15'd1;
         mA  = newA;
      end
   endtask

   // Memory responders and monitor, evaluated on the falling edge so that
   // acks are set up for the next rising edge and DUT outputs are stable.
   initial begin
      imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            iActive = 0; dActive = 0; postPending = 0;
            imem_ack = 1'b0; dmem_ack = 1'b0;
            cyc = 0; waits = 0; reads = 0; writes = 0;
            mA = '0; mD = '0; mPC = '0;
         end else begin
            if (postPending) begin
               checkOutput("pc", pc, mPC);
               checkOutput("regD", alu_x, mD);
               checkOutput("regA", dmem_addr, mA[14:0]);
               postPending = 0;
            end
            if (imem_req) begin
               if (!iActive) begin
                  iActive  = 1;
                  iWait    = $urandom_range(0, 2);
                  curFetch = (dirQ.size() > 0) ? dirQ.pop_front() : randInstr();
                  checkOutput("fetchAddr", imem_addr, mPC);
               end
               imem_ack   = (iWait == 0);
               imem_rdata = (iWait == 0) ? curFetch : 16'($urandom);
               if (iWait > 0) iWait--; else iActive = 0;
            end else begin
               imem_ack   = 1'($urandom_range(0, 1));
               imem_rdata = 16'($urandom);
            end
            if (dmem_re || dmem_we) begin
               if (!dActive) begin
                  dActive = 1;
                  dWait   = (forceDWait >= 0) ? forceDWait : $urandom_range(0, 2);
                  checkOutput("dmemAddr", dmem_addr, mA[14:0]);
               end
               dmem_ack   = (dWait == 0) && !(holdDAck && dmem_we);
               dmem_rdata = dmem_ack ? ram[dmem_addr] : 16'($urandom);
               if (dmem_ack) begin
                  dActive = 0;
                  if (dmem_re) reads++;
                  if (dmem_we) begin
                     writes++;
                     wAddr = dmem_addr;
                     wData = dmem_wdata;
                     ram[dmem_addr] = dmem_wdata;
                  end
               end else if (dWait > 0) begin
                  dWait--;
               end
            end else begin
               dmem_ack   = 1'($urandom_range(0, 1));
               dmem_rdata = 16'($urandom);
            end
            cyc++;
            if ((imem_req && !imem_ack) || ((dmem_re || dmem_we) && !dmem_ack)) waits++;
            checkOutput("exclusive", (imem_req && (dmem_re || dmem_we)) || (dmem_re && dmem_we), 0);
            if (instr_done) begin
               runModel(curFetch);
               retired++;
               cyc = 0; waits = 0; reads = 0; writes = 0;
               postPending = 1;
            end
         end
      end
   end

   // Main sequence: reset, directed program, random program, mid-write reset.
   initial begin
      int budget;
      rst = 1'b1;
      holdDAck = 0; forceDWait = 2; retired = 0;
      for (int i = 0; i < 32768; i++) begin
         ram[i]    = 16'($urandom);
         refMem[i] = ram[i];
      end
      ram[7] = 16'h1234; refMem[7] = 16'h1234;

      applyStimulus(16'h0005); applyStimulus(16'hEC10);
      applyStimulus(16'hE7C8);
      applyStimulus(16'h0007); applyStimulus(16'hFC10);
      applyStimulus(16'hEA90); applyStimulus(16'h0010); applyStimulus(16'hE302);
      applyStimulus(16'hEFD0); applyStimulus(16'h0010); applyStimulus(16'hE302);
      applyStimulus(16'h7FFF); applyStimulus(16'hEA87); applyStimulus(16'h1234);

      repeat (3) @(negedge clk);
      checkOutput("rstImemReq", imem_req, 0);
      checkOutput("rstDone", instr_done, 0);
      checkOutput("rstPc", pc, 0);
      checkOutput("rstD", alu_x, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("firstReq", imem_req, 1);

      budget = 0;
      while (retired < 14 && budget < 500) begin @(negedge clk); budget++; end
      if (retired < 14) checkOutput("directedTimeout", retired, 14);
      forceDWait = -1;
      budget = 0;
      while (retired < 314 && budget < 20000) begin @(negedge clk); budget++; end
      if (retired < 314) checkOutput("randomTimeout", retired, 314);

      applyStimulus(16'h0009); applyStimulus(16'hE308);
      holdDAck = 1;
      budget = 0;
      while (!dmem_we && budget < 200) begin @(negedge clk); budget++; end
      checkOutput("reachMwrite", dmem_we, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("abortWe", dmem_we, 0);
      checkOutput("abortImem", imem_req, 0);
      holdDAck = 0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("restartPc", pc, 0);
      checkOutput("restartD", alu_x, 0);
      checkOutput("restartA", dmem_addr, 0);
      checkOutput("restartReq", imem_req, 1);
      checkOutput("restartAddr", imem_addr, 0);

      budget = 0;
      while (retired < 334 && budget < 2000) begin @(negedge clk); budget++; end
      if (retired < 334) checkOutput("finalTimeout", retired, 334);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle Hack control core: fetches 16-bit instructions, decodes them, drives the control and operand inputs of the external 16-bit Hack ALU, and owns the A, D, PC and instruction registers. It sits between instruction memory, data memory and the ALU, and issues the zx/nx/zy/ny/f/no controls the ALU consumes. Memory accesses use a req/ack handshake, so wait-stated RAM/ROM is supported.

## Interface
- No parameters; all widths are fixed by the Hack ISA: 16-bit data, 15-bit addresses.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address; equals PC
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_re  out  1  data read request
- dmem_we  out  1  data write request
- dmem_addr  out  15  equals A[14:0] of the current instruction
- dmem_wdata  out  16  write data (result register R)
- dmem_ack  in  1  data access complete; dmem_rdata valid on read
- dmem_rdata  in  16  data read word
- alu_x  out  16  always D
- alu_y  out  16  M register if IR[12]=1, else A
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  IR[11], IR[10], IR[9], IR[8], IR[7], IR[6]
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1 each  ALU zero and negative flags
- pc  out  15  current PC
- instr_done  out  1  one-cycle pulse when an instruction retires

## Operation
- Registers: IR[15:0], A[15:0], D[15:0], M[15:0] (read latch), R[15:0] (result), J (jump flag), PC[14:0].
- States: FETCH, DECODE, MREAD, EXEC, MWRITE, COMMIT.
- FETCH: imem_req=1. On imem_ack, IR<=imem_rdata and go to DECODE.
- DECODE, A-instruction (IR[15]=0): A<={1'b0,IR[14:0]}, PC<=PC+1, instr_done=1, go to FETCH.
- DECODE, C-instruction (IR[15]=1; IR[14:13] ignored): go to MREAD if IR[12]=1, else EXEC.
- MREAD: dmem_re=1. On dmem_ack, M<=dmem_rdata and go to EXEC.
- EXEC: R<=alu_out; J<=(IR[2]&alu_ng)|(IR[1]&alu_zr)|(IR[0]&~alu_ng&~alu_zr). Go to MWRITE if IR[3]=1, else COMMIT.
- MWRITE: dmem_we=1, dmem_wdata=R. On dmem_ack, go to COMMIT.
- COMMIT: if IR[5], A<=R; if IR[4], D<=R; PC<=J ? A[14:0] : PC+1, using the pre-commit A. Assert instr_done=1 and go to FETCH.
- dmem_addr is always driven from pre-commit A. Dest A is not written before MWRITE.
- PC arithmetic is 15-bit: 0x7FFF+1 wraps to 0x0000.
- ALU outputs are sampled only in EXEC. alu_* outputs are combinational from IR/A/D/M in every state.

## Timing
- Reset values: PC=0, A=0, D=0, M=0, R=0, IR=0, J=0, state=FETCH. All req/we/re and instr_done are 0 while rst is high.
- The first imem_req rises in the first cycle after rst deasserts.
- Requests stay high, with address and data stable, until the ack cycle and drop the cycle after it.
- A same-cycle ack (zero-wait memory) is legal. Acks outside the matching request state are ignored.
- Latency with zero-wait memory: A-instruction 2 cycles. C-instruction 4 cycles, +1 if it reads M, +1 if it writes M. Each wait cycle adds 1.
- Reset asserted mid-transaction aborts immediately: requests drop asynchronously and there is no partial register commit. After release the core restarts at PC=0.
- dmem_re and dmem_we are never high in the same cycle. imem_req is never high alongside either of them.

## Test plan
- Reset, then 0x0005 followed by 0xEC10 (D=A) -> A=5; D=5 after the 6th cycle; ALU controls 110000 observed in EXEC; PC=2.
- With A=5, D=5, execute 0xE7C8 (M=D+1) with a 3-cycle dmem_ack delay -> dmem_we held for 3 cycles; addr=5, wdata=6; A and D unchanged; PC increments.
- Memory word 7 holds 0x1234; execute @7 then 0xFC10 (D=M) -> one dmem_re at addr 7; alu_y=0x1234; D=0x1234.
- With D=0 and A=0x0010, execute 0xE302 (D;JEQ) -> PC=0x0010. Repeat with D=1 -> PC=PC+1.
- With A=0x7FFF, execute 0xEA87 (0;JMP) -> PC=0x7FFF. Next A-instruction at 0x7FFF -> PC wraps to 0x0000.
- Assert rst while in MWRITE with dmem_ack held low -> dmem_we drops the same cycle; A, D and PC read 0; fetch restarts at address 0.
